// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file.
//   NREAD combinational read ports, two synchronous write ports (port 1 wins
//   on an address clash), optional hardwired-zero r0, optional write-to-read
//   bypass. After reset a clear sweep zeroes one entry per cycle; ready goes
//   high once every entry has been cleared.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ra / rd           packed read addresses / read data, port i in slice i
//   we0/wa0/wd0       write port 0 (lower priority)
//   we1/wa1/wd1       write port 1 (higher priority)
//   ready             clear sweep finished, writes accepted
//   clr_idx           current clear-sweep index
//   dbg               contents of register DEBUG_IDX (read-port semantics)
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NREAD     = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int DEBUG_IDX = 2,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd,
  input  logic                  we0,
  input  logic [AW-1:0]         wa0,
  input  logic [XLEN-1:0]       wd0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa1,
  input  logic [XLEN-1:0]       wd1,
  output logic                  ready,
  output logic [AW-1:0]         clr_idx,
  output logic [XLEN-1:0]       dbg
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // One extra bit so that NREGS itself fits, even when NREGS is a power of 2.
  localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0] DBG_A    = AW'(DEBUG_IDX);
  localparam bit            DBG_OK   = (DEBUG_IDX < NREGS);

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_q, clr_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic              ready_s;
  logic              commit0_s, commit1_s;

  // An address names real, writable storage: inside the array and not a
  // hardwired-zero r0. Reads of anything else return 0.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign ready_s   = (state_q == ST_READY);
  assign commit0_s = ready_s && we0 && addr_ok(wa0);
  assign commit1_s = ready_s && we1 && addr_ok(wa1);

  // Read mux shared by every read port and dbg. Bypass checks port 1 first
  // so that the forwarded value matches what the edge will store.
  function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (!ready_s || !addr_ok(a)) begin
      v = '0;
    end else if ((BYPASS != 0) && commit1_s && (wa1 == a)) begin
      v = wd1;
    end else if ((BYPASS != 0) && commit0_s && (wa0 == a)) begin
      v = wd0;
    end else begin
      v = mem_q[a];
    end
    return v;
  endfunction

  // Sweep sequencing: advance the clear index until the last entry is done.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_q == LAST_IDX) begin
          state_d = ST_READY;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + AW'(1);
        end
      end
      ST_READY: begin
        state_d = ST_READY;
        clr_d   = '0;
      end
      default: begin
        state_d = ST_CLEAR;
        clr_d   = '0;
      end
    endcase
  end

  // State and sweep-index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Storage: sweep clear in CLEAR, port writes in READY (port 1 last wins).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_q] <= '0;
      end else begin
        if (commit0_s) mem_q[wa0] <= wd0;
        if (commit1_s) mem_q[wa1] <= wd1;
      end
    end
  end

  // Combinational read ports and debug tap.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd[i*XLEN +: XLEN] = read_mux(ra[i*AW +: AW]);
    end
    if (DBG_OK) begin
      dbg = read_mux(DBG_A);
    end else begin
      dbg = '0;
    end
  end

  assign ready   = ready_s;
  assign clr_idx = clr_q;

endmodule
